// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's M stage: word-addressed RAM plus a
// 16-byte register window (IO_OUT, CYCLE, HALT, WRCOUNT) with combinational reads.
module data_mem_responder #(
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_WORDS  = 64,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      MemWriteM,
    input  logic [DATA_WIDTH*2-1:0]   ALUOutM,
    input  logic [DATA_WIDTH-1:0]     WriteDataM,
    output logic [DATA_WIDTH-1:0]     ReadDataM,
    output logic [DATA_WIDTH-1:0]     IoOut,
    output logic [DATA_WIDTH-1:0]     CycleCount,
    output logic                      Halted,
    output logic                      AddrFault
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {
        REG_IO_OUT  = 2'd0,
        REG_CYCLE   = 2'd1,
        REG_HALT    = 2'd2,
        REG_WRCOUNT = 2'd3
    } reg_sel_e;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] r_io_out;
    logic [DATA_WIDTH-1:0] r_cycle;
    logic [DATA_WIDTH-1:0] r_wrcount;
    logic                  r_halted;
    logic                  r_fault;

    logic [31:0]           w_addr;
    logic [IDX_W-1:0]      w_idx;
    reg_sel_e              w_sel;
    logic                  w_ram_hit;
    logic                  w_mmio_hit;
    logic                  w_aligned;
    logic                  w_wr_accept;
    logic                  w_wr_fault;
    logic                  w_ram_wr;
    logic                  w_mmio_wr;
    logic                  w_unused_addr_hi;

    // Only the low 32 address bits are decoded.
    assign w_addr           = ALUOutM[31:0];
    assign w_unused_addr_hi = ^ALUOutM[DATA_WIDTH*2-1:32];
    assign w_idx            = w_addr[IDX_W+1:2];
    assign w_sel            = reg_sel_e'(w_addr[3:2]);
    assign w_ram_hit        = (w_addr < RAM_BYTES);
    assign w_mmio_hit       = (w_addr[31:4] == MMIO_BASE[31:4]);
    assign w_aligned        = (w_addr[1:0] == 2'b00);

    // Once halted, stores are dropped silently, including faulting ones.
    assign w_wr_accept = MemWriteM && !r_halted;
    assign w_wr_fault  = w_wr_accept && (!w_aligned || !(w_ram_hit || w_mmio_hit));
    assign w_ram_wr    = w_wr_accept && w_aligned && w_ram_hit;
    assign w_mmio_wr   = w_wr_accept && w_aligned && w_mmio_hit;

    always_comb begin
        ReadDataM = '0;
        if (w_ram_hit) begin
            ReadDataM = r_mem[w_idx];
        end else if (w_mmio_hit) begin
            case (w_sel)
                REG_IO_OUT:  ReadDataM = r_io_out;
                REG_CYCLE:   ReadDataM = r_cycle;
                REG_HALT:    ReadDataM = {{(DATA_WIDTH-1){1'b0}}, r_halted};
                REG_WRCOUNT: ReadDataM = r_wrcount;
                default:     ReadDataM = '0;
            endcase
        end
    end

    // NOTE: the RAM array has no reset branch so it maps onto block RAM; its
    // power-up contents are undefined and reset only suppresses the store.
    always_ff @(posedge clk) begin
        if (!reset && w_ram_wr) begin
            r_mem[w_idx] <= WriteDataM;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values; the later CYCLE assignment overrides the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_out  <= '0;
            r_cycle   <= '0;
            r_wrcount <= '0;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
        end else if (!r_halted) begin
            r_cycle <= r_cycle + 1'b1;
            if (w_wr_fault) begin
                r_fault <= 1'b1;
            end
            if (w_ram_wr) begin
                r_wrcount <= r_wrcount + 1'b1;
            end
            if (w_mmio_wr) begin
                case (w_sel)
                    REG_IO_OUT: r_io_out <= WriteDataM;
                    REG_CYCLE:  r_cycle  <= WriteDataM;
                    REG_HALT:   if (WriteDataM[0]) r_halted <= 1'b1;
                    default:    ;
                endcase
            end
        end
    end

    assign IoOut      = r_io_out;
    assign CycleCount = r_cycle;
    assign Halted     = r_halted;
    assign AddrFault  = r_fault;

endmodule
